// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download sequencer.
package rom_dl_pkg;

    localparam int unsigned DL_AW = 25;
    localparam logic [DL_AW-1:0] DL_ROM_SIZE = 25'h14960;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        HOLD,
        READY
    } dl_state_t;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [DL_AW-1:0] sat_inc(input logic [DL_AW-1:0] v,
                                                 input logic [DL_AW-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/rom_dl_strobe.sv
// Write-strobe stretcher: a start pulse raises active_o for WR_HOLD cycles;
// done_o marks the last active cycle.
module rom_dl_strobe #(
    parameter int unsigned WR_HOLD = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic active_o,
    output logic done_o
);

    localparam logic [3:0] HoldLast = 4'(WR_HOLD - 1);

    logic       active_q, active_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        done_o   = active_q && (cnt_q == 4'd0);
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = HoldLast;
        end else if (active_q) begin
            if (cnt_q == 4'd0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/rom_dl_sequencer.sv
// Qualifies hps_io ROM download bytes into stretched eprom writes and gates core reset.
// Optional checksum (EXP_SUM parameter, CSUM_OK port) is enabled by defining ROM_CHECKSUM_EN.
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter logic [7:0]       ROM_INDEX = 8'd0,
    parameter logic [DL_AW-1:0] ROM_SIZE  = DL_ROM_SIZE,
    parameter int unsigned      WR_HOLD   = 2,
    parameter int unsigned      POST_HOLD = 16
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [15:0]      EXP_SUM   = 16'h0000
`endif
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IOCTL_DOWNLOAD,
    input  logic [7:0]       IOCTL_INDEX,
    input  logic             IOCTL_WR,
    input  logic [DL_AW-1:0] IOCTL_ADDR,
    input  logic [7:0]       IOCTL_DOUT,
    output logic             IOCTL_WAIT,
    output logic [DL_AW-1:0] ADDR_DL,
    output logic [7:0]       DATA_DL,
    output logic             WR_DL,
    output logic             CORE_RESET,
    output logic             ROM_READY,
    output logic [DL_AW-1:0] BYTE_COUNT,
    output logic             ERR_SHORT,
    output logic             ERR_OVER,
    output logic             ERR_ORDER
`ifdef ROM_CHECKSUM_EN
    ,
    output logic             CSUM_OK
`endif
);

    localparam logic [7:0] PostLast = 8'(POST_HOLD - 1);

    dl_state_t        state_q, state_d;
    logic             sel, sel_q, sel_rise;
    logic [DL_AW-1:0] addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [DL_AW-1:0] count_q, count_d;
    logic             err_short_q, err_short_d;
    logic             err_over_q, err_over_d;
    logic             err_order_q, err_order_d;
    logic             core_reset_q, core_reset_d;
    logic             ready_q, ready_d;
    logic [7:0]       hold_q, hold_d;
    logic             start_wr, wr_done, wr_active, go_hold, csum_good;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]      sum_q, sum_d;
    logic             csum_ok_q, csum_ok_d;
    assign csum_good = (sum_q == EXP_SUM);
`else
    assign csum_good = 1'b1;
`endif

    assign sel      = IOCTL_DOWNLOAD && (IOCTL_INDEX == ROM_INDEX);
    assign sel_rise = sel && !sel_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        count_d      = count_q;
        err_short_d  = err_short_q;
        err_over_d   = err_over_q;
        err_order_d  = err_order_q;
        core_reset_d = core_reset_q;
        ready_d      = ready_q;
        hold_d       = hold_q;
        start_wr     = 1'b0;
        go_hold      = 1'b0;
`ifdef ROM_CHECKSUM_EN
        sum_d        = sum_q;
        csum_ok_d    = csum_ok_q;
`endif

        unique case (state_q)
            IDLE, READY: begin
                if (sel_rise) begin
                    state_d      = LOAD;
                    count_d      = '0;
                    err_short_d  = 1'b0;
                    err_over_d   = 1'b0;
                    err_order_d  = 1'b0;
                    ready_d      = 1'b0;
                    core_reset_d = 1'b1;
`ifdef ROM_CHECKSUM_EN
                    sum_d        = 16'h0000;
                    csum_ok_d    = 1'b0;
`endif
                end
            end
            LOAD: begin
                // sel_q keeps a byte that coincides with the download falling edge.
                if (IOCTL_WR && (sel || sel_q)) begin
                    if (IOCTL_ADDR < ROM_SIZE) begin
                        addr_d   = IOCTL_ADDR;
                        data_d   = IOCTL_DOUT;
                        start_wr = 1'b1;
                        count_d  = sat_inc(count_q, ROM_SIZE);
                        state_d  = WRITE;
                        if (IOCTL_ADDR != count_q) begin
                            err_order_d = 1'b1;
                        end
`ifdef ROM_CHECKSUM_EN
                        sum_d = sum_q + {8'h00, IOCTL_DOUT};
`endif
                    end else begin
                        err_over_d = 1'b1;
                        go_hold    = !sel;
                    end
                end else if (!sel) begin
                    go_hold = 1'b1;
                end
            end
            WRITE: begin
                if (wr_done) begin
                    if (sel) begin
                        state_d = LOAD;
                    end else begin
                        go_hold = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d      = READY;
                    core_reset_d = err_short_q;
                    ready_d      = !err_short_q && csum_good;
`ifdef ROM_CHECKSUM_EN
                    csum_ok_d    = csum_good;
`endif
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_hold) begin
            state_d     = HOLD;
            hold_d      = PostLast;
            err_short_d = (count_q < ROM_SIZE);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= 8'h00;
            count_q      <= '0;
            err_short_q  <= 1'b0;
            err_over_q   <= 1'b0;
            err_order_q  <= 1'b0;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            hold_q       <= 8'd0;
`ifdef ROM_CHECKSUM_EN
            sum_q        <= 16'h0000;
            csum_ok_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel;
            addr_q       <= addr_d;
            data_q       <= data_d;
            count_q      <= count_d;
            err_short_q  <= err_short_d;
            err_over_q   <= err_over_d;
            err_order_q  <= err_order_d;
            core_reset_q <= core_reset_d;
            ready_q      <= ready_d;
            hold_q       <= hold_d;
`ifdef ROM_CHECKSUM_EN
            sum_q        <= sum_d;
            csum_ok_q    <= csum_ok_d;
`endif
        end
    end

    rom_dl_strobe #(
        .WR_HOLD (WR_HOLD)
    ) u_strobe (
        .clk_i    (CLK),
        .rst_ni   (RESET_N),
        .start_i  (start_wr),
        .active_o (wr_active),
        .done_o   (wr_done)
    );

    assign IOCTL_WAIT = wr_active;
    assign WR_DL      = wr_active;
    assign ADDR_DL    = addr_q;
    assign DATA_DL    = data_q;
    assign BYTE_COUNT = count_q;
    assign CORE_RESET = core_reset_q;
    assign ROM_READY  = ready_q;
    assign ERR_SHORT  = err_short_q;
    assign ERR_OVER   = err_over_q;
    assign ERR_ORDER  = err_order_q;
`ifdef ROM_CHECKSUM_EN
    assign CSUM_OK    = csum_ok_q;
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Scoreboard bench for rom_dl_sequencer with a reduced ROM_SIZE to keep runs short.
module tb_rom_dl_sequencer;

    localparam logic [24:0] SIZE      = 25'h200;
    localparam int unsigned WR_HOLD   = 2;
    localparam int unsigned POST_HOLD = 16;
    localparam logic [15:0] EXP       = 16'hFF00;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IOCTL_DOWNLOAD = 1'b0;
    logic [7:0]  IOCTL_INDEX = 8'd0;
    logic        IOCTL_WR = 1'b0;
    logic [24:0] IOCTL_ADDR = '0;
    logic [7:0]  IOCTL_DOUT = 8'h00;
    logic        IOCTL_WAIT, WR_DL, CORE_RESET, ROM_READY;
    logic        ERR_SHORT, ERR_OVER, ERR_ORDER;
    logic [24:0] ADDR_DL, BYTE_COUNT;
    logic [7:0]  DATA_DL;
`ifdef ROM_CHECKSUM_EN
    logic        CSUM_OK;
`endif

    rom_dl_sequencer #(
        .ROM_INDEX (8'd0),
        .ROM_SIZE  (SIZE),
        .WR_HOLD   (WR_HOLD),
        .POST_HOLD (POST_HOLD)
`ifdef ROM_CHECKSUM_EN
        ,
        .EXP_SUM   (EXP)
`endif
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .IOCTL_DOWNLOAD (IOCTL_DOWNLOAD),
        .IOCTL_INDEX    (IOCTL_INDEX),
        .IOCTL_WR       (IOCTL_WR),
        .IOCTL_ADDR     (IOCTL_ADDR),
        .IOCTL_DOUT     (IOCTL_DOUT),
        .IOCTL_WAIT     (IOCTL_WAIT),
        .ADDR_DL        (ADDR_DL),
        .DATA_DL        (DATA_DL),
        .WR_DL          (WR_DL),
        .CORE_RESET     (CORE_RESET),
        .ROM_READY      (ROM_READY),
        .BYTE_COUNT     (BYTE_COUNT),
        .ERR_SHORT      (ERR_SHORT),
        .ERR_OVER       (ERR_OVER),
        .ERR_ORDER      (ERR_ORDER)
`ifdef ROM_CHECKSUM_EN
        ,
        .CSUM_OK        (CSUM_OK)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [24:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t sb_q[$];

    // Reference model of the download bookkeeping.
    bit          m_active, m_short, m_over, m_order;
    logic [24:0] m_count;
    logic [15:0] m_sum;

    // Monitor: every WR_DL pulse must match the next expected byte and last WR_HOLD cycles.
    initial begin
        logic wr_prev;
        int   run_len;
        wr_t  cur;
        wr_prev = 1'b0;
        run_len = 0;
        cur     = '0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                wr_prev = 1'b0;
                run_len = 0;
            end else begin
                if (WR_DL && !wr_prev) begin
                    check_eq("wr_expected", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) cur = sb_q.pop_front();
                    run_len = 0;
                end
                if (WR_DL) begin
                    run_len++;
                    check_eq("addr_dl", 32'(ADDR_DL), 32'(cur.a));
                    check_eq("data_dl", 32'(DATA_DL), 32'(cur.d));
                    check_eq("wait_with_wr", 32'(IOCTL_WAIT), 32'd1);
                end
                if (!WR_DL && wr_prev) check_eq("wr_len", 32'(run_len), 32'(WR_HOLD));
                wr_prev = WR_DL;
            end
        end
    end

    task automatic begin_dl(input logic [7:0] idx);
        @(posedge CLK); #1;
        IOCTL_INDEX    = idx;
        IOCTL_DOWNLOAD = 1'b1;
        if (idx == 8'd0) begin
            m_active = 1'b1;
            m_count  = '0;
            m_short  = 1'b0;
            m_over   = 1'b0;
            m_order  = 1'b0;
            m_sum    = 16'h0000;
        end
        repeat (2) @(posedge CLK);
    endtask

    task automatic end_dl();
        @(posedge CLK); #1;
        IOCTL_DOWNLOAD = 1'b0;
        if (m_active) begin
            m_active = 1'b0;
            m_short  = (m_count < SIZE);
        end
    endtask

    // One byte per three cycles; drop lowers the download on the same cycle as the strobe.
    task automatic send(input logic [24:0] a, input logic [7:0] d, input bit drop);
        wr_t e;
        @(posedge CLK); #1;
        IOCTL_ADDR = a;
        IOCTL_DOUT = d;
        IOCTL_WR   = 1'b1;
        if (drop) IOCTL_DOWNLOAD = 1'b0;
        if (m_active && IOCTL_INDEX == 8'd0) begin
            if (a < SIZE) begin
                e.a = a;
                e.d = d;
                sb_q.push_back(e);
                if (a != m_count) m_order = 1'b1;
                if (m_count < SIZE) m_count = m_count + 25'd1;
                m_sum = m_sum + {8'h00, d};
            end else begin
                m_over = 1'b1;
            end
        end
        if (drop && m_active) begin
            m_active = 1'b0;
            m_short  = (m_count < SIZE);
        end
        @(posedge CLK); #1;
        IOCTL_WR = 1'b0;
        @(posedge CLK);
    endtask

    task automatic load_seq(input int n, input int bad_at);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = (i == bad_at) ? 8'hAA : 8'(i);
            send(25'(i), d, 1'b0);
        end
    endtask

    task automatic check_final(input string pfx);
        bit good;
        good = !m_short;
`ifdef ROM_CHECKSUM_EN
        good = good && (m_sum == EXP);
`endif
        repeat (POST_HOLD + 6) @(posedge CLK);
        @(negedge CLK);
        check_eq({pfx, "_core_reset"}, 32'(CORE_RESET), 32'(m_short));
        check_eq({pfx, "_rom_ready"}, 32'(ROM_READY), 32'(good));
        check_eq({pfx, "_err_short"}, 32'(ERR_SHORT), 32'(m_short));
        check_eq({pfx, "_err_over"}, 32'(ERR_OVER), 32'(m_over));
        check_eq({pfx, "_err_order"}, 32'(ERR_ORDER), 32'(m_order));
        check_eq({pfx, "_byte_count"}, 32'(BYTE_COUNT), 32'(m_count));
        check_eq({pfx, "_wait"}, 32'(IOCTL_WAIT), 32'd0);
`ifdef ROM_CHECKSUM_EN
        check_eq({pfx, "_csum_ok"}, 32'(CSUM_OK), 32'(m_sum == EXP));
`endif
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_core_reset"}, 32'(CORE_RESET), 32'd1);
        check_eq({pfx, "_rom_ready"}, 32'(ROM_READY), 32'd0);
        check_eq({pfx, "_byte_count"}, 32'(BYTE_COUNT), 32'd0);
        check_eq({pfx, "_wr_dl"}, 32'(WR_DL), 32'd0);
        check_eq({pfx, "_wait"}, 32'(IOCTL_WAIT), 32'd0);
        check_eq({pfx, "_addr_dl"}, 32'(ADDR_DL), 32'd0);
        check_eq({pfx, "_data_dl"}, 32'(DATA_DL), 32'd0);
        check_eq({pfx, "_errs"}, 32'({ERR_SHORT, ERR_OVER, ERR_ORDER}), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_active = 1'b0;
        m_short  = 1'b0;
        m_over   = 1'b0;
        m_order  = 1'b0;
        m_count  = '0;
        m_sum    = 16'h0000;

        // Reset values, and no reaction to a stray strobe outside a download.
        repeat (3) @(negedge CLK);
        check_reset_vals("rst");
        RESET_N = 1'b1;
        send(25'd0, 8'h55, 1'b0);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check_reset_vals("idle");

        // Full sequential image.
        begin_dl(8'd0);
        load_seq(int'(SIZE), -1);
        @(negedge CLK);
        check_eq("full_count", 32'(BYTE_COUNT), 32'(SIZE));
        check_eq("full_not_ready", 32'(ROM_READY), 32'd0);
        end_dl();
        repeat (POST_HOLD - 3) @(posedge CLK);
        @(negedge CLK);
        check_eq("hold_core_reset", 32'(CORE_RESET), 32'd1);
        check_final("full");

        // Other index while READY must not disturb anything.
        begin_dl(8'd1);
        send(25'd0, 8'h12, 1'b0);
        send(25'd1, 8'h34, 1'b0);
        end_dl();
        check_final("wrong_idx");

        // Short image; restart must drop ROM_READY and assert CORE_RESET.
        begin_dl(8'd0);
        @(negedge CLK);
        check_eq("restart_ready", 32'(ROM_READY), 32'd0);
        check_eq("restart_core_reset", 32'(CORE_RESET), 32'd1);
        check_eq("restart_count", 32'(BYTE_COUNT), 32'd0);
        load_seq(int'(SIZE / 2), -1);
        end_dl();
        check_final("short");

        // Skip 5->7, then an overrun byte that must not be written.
        begin_dl(8'd0);
        load_seq(6, -1);
        send(25'd7, 8'h07, 1'b0);
        send(SIZE, 8'hEE, 1'b0);
        end_dl();
        check_final("order_over");

        // Download falls while the write is still in progress.
        begin_dl(8'd0);
        @(posedge CLK); #1;
        IOCTL_ADDR = 25'd0;
        IOCTL_DOUT = 8'h3C;
        IOCTL_WR   = 1'b1;
        sb_q.push_back('{a: 25'd0, d: 8'h3C});
        m_count = 25'd1;
        m_sum   = 16'h003C;
        @(posedge CLK); #1;
        IOCTL_WR       = 1'b0;
        IOCTL_DOWNLOAD = 1'b0;
        m_active = 1'b0;
        m_short  = 1'b1;
        @(negedge CLK);
        check_eq("fall_in_write_wait", 32'(IOCTL_WAIT), 32'd1);
        check_final("fall_in_write");

        // Last byte coincides with the download falling edge.
        begin_dl(8'd0);
        load_seq(int'(SIZE) - 1, -1);
        send(SIZE - 25'd1, 8'(SIZE - 25'd1), 1'b1);
        check_final("simul_fall");

        // Reset in the middle of a load, then a clean reload.
        begin_dl(8'd0);
        load_seq(100, -1);
        @(posedge CLK); #1;
        RESET_N        = 1'b0;
        IOCTL_DOWNLOAD = 1'b0;
        m_active = 1'b0;
        #2;
        check_reset_vals("midrst");
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        begin_dl(8'd0);
        load_seq(int'(SIZE), -1);
        end_dl();
        check_final("reload");

`ifdef ROM_CHECKSUM_EN
        // Complete image with one corrupted byte.
        begin_dl(8'd0);
        load_seq(int'(SIZE), 3);
        end_dl();
        check_final("bad_sum");
`endif

        repeat (4) @(posedge CLK);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
